// File: rtl/snake_framebuf.sv
// snake_framebuf: 32x32 RGB frame buffer feeding the LED scan driver; FB_DOUBLE_BUFFER_EN selects front/back banks with frame-boundary swaps
module snake_framebuf #(
    parameter int COLS      = 32,
    parameter int HALF_ROWS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_rgb,
    output logic       wr_ready,
    input  logic       clear_req,
    input  logic       swap_req,
    output logic       swap_pending,
    output logic       swap_done,
    input  logic [3:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [7:0] led_data
);
`ifdef FB_DOUBLE_BUFFER_EN
    localparam int AW = 11;
`else
    localparam int AW = 10;
`endif
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [3:0] LAST_ROW = 4'(HALF_ROWS - 1);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t          state, state_next;
    logic [9:0]      clr_addr;
    logic [9:0]      wa_raw;
    logic [2:0]      wd;
    logic            we;
    logic            front_sel;
    logic            boundary;
    logic [AW-1:0]   wa, ra_hi, ra_lo;
    logic [2:0]      mem [0:(1<<AW)-1];
    assign boundary = rd_row == LAST_ROW && rd_col == LAST_COL;
    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    // Next state and write-port mux: game writes in IDLE, zero fill in CLEAR
    always_comb begin
        state_next = state;
        wr_ready   = 1'b0;
        we         = 1'b0;
        wa_raw     = {wr_y, wr_x};
        wd         = wr_rgb;
        if (state == IDLE) begin
            wr_ready = 1'b1;
            if (clear_req) state_next = CLEAR;
            else           we = wr_en;
        end else begin
            we     = 1'b1;
            wa_raw = clr_addr;
            wd     = 3'b000;
            if (clr_addr == 10'h3ff) state_next = IDLE;
        end
    end
    // Clear address walks 0..1023 while clearing and rests at 0 otherwise
    always_ff @(posedge clk) begin
        if (reset)               clr_addr <= '0;
        else if (state == CLEAR) clr_addr <= clr_addr + 10'd1;
        else                     clr_addr <= '0;
    end
`ifdef FB_DOUBLE_BUFFER_EN
    logic do_swap;
    assign do_swap = boundary && swap_pending && state == IDLE;
    assign wa      = {~front_sel, wa_raw};
    assign ra_hi   = {front_sel, 1'b0, rd_row, rd_col};
    assign ra_lo   = {front_sel, 1'b1, rd_row, rd_col};
    // Swap bookkeeping: requests merge while pending and take effect only at an idle frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            front_sel    <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            front_sel    <= front_sel ^ do_swap;
            swap_pending <= !do_swap && (swap_pending || swap_req);
            swap_done    <= do_swap;
        end
    end
`else
    logic unused;
    assign front_sel    = 1'b0;
    assign swap_pending = 1'b0;
    assign swap_done    = 1'b0;
    assign wa           = wa_raw;
    assign ra_hi        = {1'b0, rd_row, rd_col};
    assign ra_lo        = {1'b1, rd_row, rd_col};
    assign unused       = ^{swap_req, boundary, front_sel};
`endif
    // Pixel store write port
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    // Registered scan read of the upper and lower half-panel pixels
    always_ff @(posedge clk) begin
        if (reset) led_data <= '0;
        else       led_data <= {2'b00, mem[ra_hi], mem[ra_lo]};
    end
endmodule

// File: doc/snake_framebuf.md
# snake_framebuf

Dual-bank 32x32 pixel frame buffer that sits directly upstream of the LED matrix scan driver. Game logic writes 3-bit RGB pixels into a back bank. The scan driver supplies its current row/column and receives the packed `led_data` byte for the upper and lower half-panels from the front bank. Bank swaps happen only at a frame boundary, so the panel never shows a half-drawn frame.

## Interface
Parameters:
- `COLS`, default 32: pixels per row; the column index is 5 bits.
- `HALF_ROWS`, default 16: rows per half-panel; the row index is 4 bits. The panel is 2*HALF_ROWS rows tall.

Ports:
- `clk` in 1: the single clock. This is the same clock as the scan driver.
- `reset` in 1: synchronous, active-high.
- `wr_en` in 1: pixel write strobe. Accepted only while `wr_ready`=1.
- `wr_x` in 5: write column, 0..31.
- `wr_y` in 5: write row, 0..31. Rows 0..15 are the upper half; rows 16..31 are the lower half.
- `wr_rgb` in 3: pixel colour {r,g,b}.
- `wr_ready` out 1: the buffer accepts writes and clear requests.
- `clear_req` in 1: pulse. Starts a fill of the back bank with 0.
- `swap_req` in 1: pulse. Requests a front/back swap at the next frame boundary.
- `swap_pending` out 1: a swap has been requested and has not yet happened.
- `swap_done` out 1: one-cycle pulse in the cycle after a swap takes effect.
- `rd_row` in 4: the scan driver's current row.
- `rd_col` in 5: the scan driver's current column.
- `led_data` out 8: {2'b00, rgb1[2:0], rgb2[2:0]}. rgb1 is pixel (rd_row, rd_col); rgb2 is pixel (rd_row+16, rd_col).

## Operation
- Storage: two banks, each 1024 x 3 bits. The address is {y[4:0], x[4:0]}. Memory contents are not reset.
- `front_sel` selects the displayed bank; the back bank is !front_sel.
- FSM states:
  - IDLE: `wr_ready`=1.
    - `clear_req` -> CLEAR with `clr_addr`=0.
    - `wr_en` (without `clear_req`) writes `wr_rgb` to back[{wr_y,wr_x}].
    - If `clear_req` and `wr_en` arrive together, the clear wins and the write is dropped.
  - CLEAR: `wr_ready`=0. Writes 0 to back[`clr_addr`] and increments `clr_addr` each cycle. After address 1023, returns to IDLE, so CLEAR lasts exactly 1024 cycles.
    - `wr_en` and `clear_req` are ignored in CLEAR.
- Swap:
  - `swap_req` sets `swap_pending`. Repeated requests while pending are merged into one.
  - Frame boundary is the cycle with `rd_row`==15 and `rd_col`==31.
  - At a boundary, if `swap_pending`=1 and the FSM is in IDLE: toggle `front_sel`, clear `swap_pending`, and pulse `swap_done` the next cycle.
  - If the FSM is in CLEAR, the swap waits for the first boundary after CLEAR ends.
- A write in the same cycle as a swap lands in the pre-swap back bank, which becomes the front.
- Read: `led_data` is registered from front[{1'b0,rd_row,rd_col}] and front[{1'b1,rd_row,rd_col}]. Bits [7:6] are always 0.

## Timing
- Reset values:
  - `led_data`=0, `front_sel`=0, `swap_pending`=0, `swap_done`=0.
  - FSM=IDLE, so `wr_ready`=1.
  - `clr_addr`=0.
- Reset in the middle of CLEAR aborts it; the remaining back-bank contents are unspecified.
- Read latency is 1 cycle: the address at edge N gives `led_data` valid after edge N.
- The boundary read of (15,31) uses the old front bank. The (0,0) read in the next cycle uses the new front bank.
- A write at edge N is visible to a front read only after a swap. A back-bank write never affects `led_data`.
- `wr_ready` falls the cycle after `clear_req` is accepted and rises the cycle after the 1024th clear write.

## Configuration
- `FB_DOUBLE_BUFFER_EN` defined: two banks, with swap behaviour as described above.
- `FB_DOUBLE_BUFFER_EN` undefined:
  - Single bank; `front_sel` is fixed at 0.
  - Writes and clears go to the displayed bank and appear on `led_data` one cycle after they are written.
  - `swap_req` is ignored; `swap_pending` and `swap_done` are held at 0.

## Test plan
- Reset then idle: `led_data`=8'h00, `wr_ready`=1, `swap_pending`=0, `swap_done`=0.
- Write (x=3,y=2,rgb=3'b100) and (x=3,y=18,rgb=3'b010), then swap_req, then scan a full frame -> after the boundary, rd_row=2, rd_col=3 gives `led_data`=8'b00_100_010. Before the boundary it gives the old front contents.
- clear_req -> `wr_ready`=0 for exactly 1024 cycles. A `wr_en` issued mid-clear is dropped. After a swap, every (row,col) reads 8'h00.
- swap_req pulsed 3 times before one boundary -> exactly one `swap_done` pulse and one `front_sel` toggle.
- swap_req during CLEAR, with a boundary occurring mid-clear -> no swap; the swap occurs at the first boundary after CLEAR ends.
- Without `FB_DOUBLE_BUFFER_EN`: write (x=0,y=0,rgb=3'b111) -> read (0,0) returns 8'b00_111_xxx with no swap, and `swap_done` stays 0.
